// File: rtl/gesture_pkg.sv
// Shared types for the gesture pipeline: key_input, gesture_filter and game_state.
package gesture_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        RIGHT = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMING = 2'b01,
        HELD   = 2'b10
    } gstate_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer and stability counter for a raw push-button; emits a
// single-cycle pulse when the debounced level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          syncMeta_q;
    logic          syncOut_q;
    logic          level_q, level_d;
    logic          levelDly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized input agrees with the debounced level
    // restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (syncOut_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            level_q    <= 1'b0;
            levelDly_q <= 1'b0;
            press_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            syncMeta_q <= btn_i;
            syncOut_q  <= syncMeta_q;
            level_q    <= level_d;
            levelDly_q <= level_q;
            press_q    <= level_q & ~levelDly_q;
            cnt_q      <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/gesture_filter.sv
// Turns per-frame gesture directions into hold-qualified, auto-repeating
// single-cycle commands, and debounces the decide button.
module gesture_filter
    import gesture_pkg::*;
#(
    parameter int HOLD_FRAMES     = 4,
    parameter int REPEAT_FRAMES   = 15,
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] key_in,
    input  logic       key_valid_in,
    input  logic       present_in,
    input  logic       decide_in,
    output logic [1:0] key_out,
    output logic       key_valid_out,
    output logic       held_out,
    output logic       decide_out
);

    localparam int FW = $clog2(maxInt(HOLD_FRAMES, REPEAT_FRAMES) + 1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
    localparam logic [FW-1:0] FCNT_MAX  = {FW{1'b1}};
    localparam logic [FW-1:0] HOLD_C    = FW'(HOLD_FRAMES);
    localparam logic [FW-1:0] REPEAT_C  = FW'(REPEAT_FRAMES);

    gstate_t       state_q, state_d;
    dir_t          cand_q, cand_d;
    dir_t          keyOut_q;
    logic          keyValid_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [FW-1:0] fcntInc;
    logic          issue;

    assign fcntInc = (fcnt_q == FCNT_MAX) ? fcnt_q : fcnt_q + 1'b1;

    // Thresholds use >= so a counter that saturated or started past the
    // limit still fires instead of stalling.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        fcnt_d  = fcnt_q;
        issue   = 1'b0;
        if (key_valid_in) begin
            unique case (state_q)
                IDLE: begin
                    if (present_in) begin
                        cand_d = dir_t'(key_in);
                        if (HOLD_FRAMES <= 1) begin
                            state_d = HELD;
                            fcnt_d  = '0;
                            issue   = 1'b1;
                        end else begin
                            state_d = ARMING;
                            fcnt_d  = FCNT_ONE;
                        end
                    end
                end
                ARMING: begin
                    if (!present_in) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else if (key_in != cand_q) begin
                        cand_d = dir_t'(key_in);
                        fcnt_d = FCNT_ONE;
                    end else if (fcntInc >= HOLD_C) begin
                        state_d = HELD;
                        fcnt_d  = '0;
                        issue   = 1'b1;
                    end else begin
                        fcnt_d = fcntInc;
                    end
                end
                HELD: begin
                    if (!present_in) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else if (key_in != cand_q) begin
                        state_d = ARMING;
                        cand_d  = dir_t'(key_in);
                        fcnt_d  = FCNT_ONE;
                    end else if (REPEAT_FRAMES != 0 && fcntInc >= REPEAT_C) begin
                        fcnt_d = '0;
                        issue  = 1'b1;
                    end else begin
                        fcnt_d = fcntInc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cand_q     <= UP;
            fcnt_q     <= '0;
            keyOut_q   <= UP;
            keyValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            fcnt_q     <= fcnt_d;
            keyValid_q <= issue;
            if (issue) begin
                keyOut_q <= cand_d;
            end
        end
    end

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_decide (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .btn_i  (decide_in),
        .press_o(decide_out)
    );

    assign key_out       = keyOut_q;
    assign key_valid_out = keyValid_q;
    assign held_out      = (state_q == HELD);

endmodule

// File: tb/tb_gesture_filter.sv
// Directed scoreboard bench for gesture_filter with HOLD=4, REPEAT=3, DEBOUNCE=8.
module tb_gesture_filter;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [1:0] key_in = 2'b00;
    logic       key_valid_in = 1'b0;
    logic       present_in = 1'b0;
    logic       decide_in = 1'b0;
    logic [1:0] key_out;
    logic       key_valid_out;
    logic       held_out;
    logic       decide_out;

    typedef struct {
        logic [1:0] key;
        int         cyc;
    } keyExp_t;

    keyExp_t keyQ[$];
    int      decQ[$];
    keyExp_t monKey;
    int      monDec;
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;

    gesture_filter #(
        .HOLD_FRAMES    (4),
        .REPEAT_FRAMES  (3),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .key_in       (key_in),
        .key_valid_in (key_valid_in),
        .present_in   (present_in),
        .decide_in    (decide_in),
        .key_out      (key_out),
        .key_valid_out(key_valid_out),
        .held_out     (held_out),
        .decide_out   (decide_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One frame: strobe for a single cycle; the command, if any, shows one cycle later.
    task automatic applyStimulus(input logic [1:0] key, input logic present, input logic expectPulse);
        @(negedge clk_in);
        key_in       = key;
        present_in   = present;
        key_valid_in = 1'b1;
        if (expectPulse) keyQ.push_back('{key: key, cyc: cyc + 1});
        @(negedge clk_in);
        key_valid_in = 1'b0;
    endtask

    task automatic pressButton();
        @(negedge clk_in);
        decide_in = 1'b1;
        decQ.push_back(cyc + 11);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " key_out"}, key_out, 0);
        checkOutput({tag, " key_valid_out"}, key_valid_out, 0);
        checkOutput({tag, " held_out"}, held_out, 0);
        checkOutput({tag, " decide_out"}, decide_out, 0);
    endtask

    // Monitor: every strobe the DUT presents must match the head of its queue.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (key_valid_out) begin
                if (keyQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected key_valid_out: key_out=%0d at cycle %0d, none expected", key_out, cyc);
                end else begin
                    monKey = keyQ.pop_front();
                    checkOutput("key_out value", key_out, monKey.key);
                    checkOutput("key_valid_out cycle", cyc, monKey.cyc);
                end
            end
            if (decide_out) begin
                if (decQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected decide_out at cycle %0d, none expected", cyc);
                end else begin
                    monDec = decQ.pop_front();
                    checkOutput("decide_out cycle", cyc, monDec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        checkAllZero("reset");
        rst_in = 1'b0;

        $display("[TB] hold and repeat");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(2'b10, 1'b1, (i == 4 || i == 7 || i == 10));
            if (i == 3) checkOutput("held_out before hold", held_out, 0);
            if (i >= 4) checkOutput("held_out while held", held_out, 1);
        end

        $display("[TB] break during arming");
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("held_out after key change", held_out, 0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b1);

        $display("[TB] loss of presence");
        applyStimulus(2'b01, 1'b0, 1'b0);
        checkOutput("held_out after presence loss", held_out, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(2'b01, 1'b1, (i == 4));
        checkOutput("held_out after rearm", held_out, 1);
        checkOutput("key_out holds", key_out, 1);

        $display("[TB] bounce");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            decide_in = ~decide_in;
            repeat (2) @(negedge clk_in);
        end
        pressButton();
        repeat (19) @(negedge clk_in);
        decide_in = 1'b0;
        repeat (15) @(negedge clk_in);

        $display("[TB] reset mid-arming");
        applyStimulus(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b1, 1'b0);
        #2 rst_in = 1'b1;
        #1 checkAllZero("reset mid-arming");
        @(negedge clk_in);
        #3 rst_in = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(2'b11, 1'b1, (i == 4));
        checkOutput("key_out after rearm", key_out, 3);

        $display("[TB] reset during decide pulse");
        pressButton();
        repeat (11) @(negedge clk_in);
        #2 rst_in = 1'b1;
        decide_in = 1'b0;
        #1 checkAllZero("reset during pulse");
        @(negedge clk_in);
        #3 rst_in = 1'b0;
        repeat (12) @(negedge clk_in);

        $display("[TB] simultaneous events");
        pressButton();
        repeat (3) @(negedge clk_in);
        for (int i = 1; i <= 4; i++) applyStimulus(2'b00, 1'b1, (i == 4));
        repeat (5) @(negedge clk_in);
        decide_in = 1'b0;
        repeat (20) @(negedge clk_in);

        checkOutput("pending key commands", keyQ.size(), 0);
        checkOutput("pending decide pulses", decQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
